// File: rtl/sevenseg_scan.sv
// sevenseg_scan: time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Digit values, decimal-point requests and the blanking mode are captured together once per
// refresh frame, so a frame never mixes old and new values. Anodes rotate once every PRESCALE
// clocks. All outputs are registered and active-low.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   d0..d3    digit values (d0 rightmost, d3 leftmost), 0x0-0xF
//   dp_en     decimal-point request per digit (bit i -> digit i), 1 = lit
//   blank_lz  1 = blank leading zeros on d3..d1 (d0 never blanked)
//   an        anode enables, active-low (bit i -> digit i)
//   seg       segments {g,f,e,d,c,b,a}, active-low
//   dp        decimal point, active-low
//   frame     one-cycle pulse in the cycle after a snapshot is taken
module sevenseg_scan #(
  parameter int unsigned PRESCALE = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] dp_en,
  input  logic       blank_lz,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(PRESCALE - 1);

  typedef enum logic [0:0] {StOff, StScan} state_e;

  // Hex to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [CntW-1:0]  cnt_q;
  logic             tick;
  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic             load;
  logic [3:0][3:0]  snap_q;
  logic [3:0]       snap_dp_q;
  logic             snap_blz_q;
  logic [3:0]       blank;
  logic [3:0]       an_d, an_q;
  logic [6:0]       seg_d, seg_q;
  logic             dp_d, dp_q;
  logic             frame_q;

  // Free-running prescaler; tick marks the last clock of each digit slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (cnt_q == CntMax) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign tick = (cnt_q == CntMax);

  // FSM state register plus the frame-synchronous snapshot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StOff;
      idx_q      <= '0;
      snap_q     <= '0;
      snap_dp_q  <= '0;
      snap_blz_q <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      frame_q <= load;
      if (load) begin
        snap_q     <= {d3, d2, d1, d0};
        snap_dp_q  <= dp_en;
        snap_blz_q <= blank_lz;
      end
    end
  end

  // Next-state logic. A snapshot is taken when leaving OFF and on every 3->0 wrap.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    unique case (state_q)
      StOff: begin
        if (tick) begin
          state_d = StScan;
          idx_d   = '0;
          load    = 1'b1;
        end
      end
      StScan: begin
        if (tick) begin
          idx_d = idx_q + 2'd1;
          load  = (idx_q == 2'd3);
        end
      end
      default: begin
        state_d = StOff;
      end
    endcase
  end

  // Leading-zero blanking ripples down from the leftmost digit.
  always_comb begin
    blank    = '0;
    blank[3] = snap_blz_q & (snap_q[3] == 4'h0);
    blank[2] = blank[3] & (snap_q[2] == 4'h0);
    blank[1] = blank[2] & (snap_q[1] == 4'h0);
  end

  // Output next-values; registered one edge after the state so outputs lag idx by a cycle.
  always_comb begin
    an_d  = 4'hF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (state_q == StScan) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = blank[idx_q] ? 7'h7F : decode(snap_q[idx_q]);
      dp_d  = ~snap_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_q  <= 4'hF;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = dp_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Bench for sevenseg_scan: two instances (PRESCALE=4 and PRESCALE=2) share the same inputs.
// A timeline model derives every expected output from the number of clock edges since reset
// release; a compare loop checks both instances on every falling edge, and a directed sequence
// pins key values with literals.
module tb_sevenseg_scan;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] d0, d1, d2, d3, dp_en;
  logic       blank_lz;

  logic [3:0] an4, an2;
  logic [6:0] seg4, seg2;
  logic       dp4, dp2, frame4, frame2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sevenseg_scan #(.PRESCALE(4)) u_dut4 (
    .clk(clk), .reset(reset), .d0(d0), .d1(d1), .d2(d2), .d3(d3), .dp_en(dp_en),
    .blank_lz(blank_lz), .an(an4), .seg(seg4), .dp(dp4), .frame(frame4)
  );

  sevenseg_scan #(.PRESCALE(2)) u_dut2 (
    .clk(clk), .reset(reset), .d0(d0), .d1(d1), .d2(d2), .d3(d3), .dp_en(dp_en),
    .blank_lz(blank_lz), .an(an2), .seg(seg2), .dp(dp2), .frame(frame2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] hexseg(input logic [3:0] v);
    logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[v];
  endfunction

  // ---------------- model ----------------
  int         pp [2] = '{4, 2};
  int         tm [2] = '{0, 0};
  logic [3:0] sd [2][4];
  logic [3:0] sdp [2] = '{4'h0, 4'h0};
  logic       sblz [2] = '{1'b0, 1'b0};
  logic [3:0] e_an [2] = '{4'hF, 4'hF};
  logic [6:0] e_seg [2] = '{7'h7F, 7'h7F};
  logic       e_dp [2] = '{1'b1, 1'b1};
  logic       e_fr [2] = '{1'b0, 1'b0};

  // A digit is blanked when blanking is on and it and every digit to its left are zero.
  function automatic logic is_blank(input int i, input int pos);
    logic b;
    if (pos == 0 || !sblz[i]) return 1'b0;
    b = 1'b1;
    for (int j = pos; j < 4; j++) if (sd[i][j] != 4'h0) b = 1'b0;
    return b;
  endfunction

  task automatic model_dark(input int i);
    tm[i] = 0;
    for (int j = 0; j < 4; j++) sd[i][j] = 4'h0;
    sdp[i] = 4'h0; sblz[i] = 1'b0;
    e_an[i] = 4'hF; e_seg[i] = 7'h7F; e_dp[i] = 1'b1; e_fr[i] = 1'b0;
  endtask

  task automatic model_edge(input int i);
    int p, u, k, pos, slot;
    p = pp[i];
    tm[i]++;
    u = tm[i] - 1;  // outputs after this edge show the slot in force after edge u
    if (u < p) begin
      e_an[i] = 4'hF; e_seg[i] = 7'h7F; e_dp[i] = 1'b1;
    end else begin
      k = u / p;
      pos = (k - 1) % 4;
      e_an[i] = 4'hF;
      e_an[i][pos] = 1'b0;
      e_seg[i] = is_blank(i, pos) ? 7'h7F : hexseg(sd[i][pos]);
      e_dp[i] = ~sdp[i][pos];
    end
    slot = tm[i] / p;
    if (tm[i] >= p && (tm[i] % p) == 0 && ((slot - 1) % 4) == 0) begin
      sd[i][0] = d0; sd[i][1] = d1; sd[i][2] = d2; sd[i][3] = d3;
      sdp[i] = dp_en; sblz[i] = blank_lz;
      e_fr[i] = 1'b1;
    end else begin
      e_fr[i] = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) model_dark(i);
    forever begin
      @(posedge clk or negedge reset);
      for (int i = 0; i < 2; i++) begin
        if (!reset) model_dark(i);
        else model_edge(i);
      end
    end
  end

  // Per-cycle comparison on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("an_p4", an4, e_an[0]);
      chk("seg_p4", seg4, e_seg[0]);
      chk("dp_p4", dp4, e_dp[0]);
      chk("frame_p4", frame4, e_fr[0]);
      chk("an_p2", an2, e_an[1]);
      chk("seg_p2", seg2, e_seg[1]);
      chk("dp_p2", dp2, e_dp[1]);
      chk("frame_p2", frame2, e_fr[1]);
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic wait_to(input int n);
    int g = 0;
    while (tm[0] < n && g < 2000) begin
      @(negedge clk);
      g++;
    end
    chk("wait_to_edge", tm[0], n);
  endtask

  task automatic lit(input string name, input logic [3:0] a, input logic [6:0] s);
    chk({name, "_an"}, an4, a);
    chk({name, "_seg"}, seg4, s);
  endtask

  function automatic logic [3:0] rdig();
    return ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
  endfunction

  initial begin
    int last, pulses, g;
    d3 = 4'h1; d2 = 4'h2; d1 = 4'h3; d0 = 4'h4; dp_en = 4'h0; blank_lz = 1'b0;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    lit("reset", 4'hF, 7'h7F);
    chk("reset_dp", dp4, 1'b1);
    chk("reset_frame", frame4, 1'b0);
    reset = 1'b1;

    // First frame timing.
    wait_to(4);
    lit("pre_first", 4'hF, 7'h7F);
    chk("first_frame", frame4, 1'b1);
    wait_to(5);
    lit("dig0", 4'hE, 7'h19);
    chk("frame_one_cycle", frame4, 1'b0);
    wait_to(9);  lit("dig1", 4'hD, 7'h30);
    wait_to(13); lit("dig2", 4'hB, 7'h24);
    d0 = 4'h9;   // mid-frame change must not appear until the next snapshot
    wait_to(17); lit("dig3", 4'h7, 7'h79);
    wait_to(20); lit("dig3_end", 4'h7, 7'h79);
    chk("second_frame", frame4, 1'b1);
    wait_to(21); lit("next_frame_d0", 4'hE, 7'h10);

    // Leading-zero blanking.
    wait_to(22);
    d3 = 4'h0; d2 = 4'h0; d1 = 4'h7; d0 = 4'h0; blank_lz = 1'b1;
    wait_to(37); lit("lz_d0", 4'hE, 7'h40);
    blank_lz = 1'b0;
    wait_to(41); lit("lz_d1", 4'hD, 7'h78);
    wait_to(45); lit("lz_d2", 4'hB, 7'h7F);
    wait_to(49); lit("lz_d3", 4'h7, 7'h7F);
    wait_to(61); lit("nolz_d2", 4'hB, 7'h40);
    wait_to(65); lit("nolz_d3", 4'h7, 7'h40);
    dp_en = 4'b0001;
    wait_to(69); lit("dp_d0", 4'hE, 7'h40);
    chk("dp_on", dp4, 1'b0);
    wait_to(73); chk("dp_off", dp4, 1'b1);

    // Full hex sweep on d0 with its decimal point lit.
    for (int v = 0; v < 16; v++) begin
      d0 = 4'(v); d1 = rdig(); d2 = rdig(); d3 = rdig();
      blank_lz = 1'($urandom_range(0, 1));
      repeat (16) @(negedge clk);
    end

    // Random stimulus, also timing the PRESCALE=2 frame period.
    last = -1; pulses = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (frame2) begin
        if (last >= 0) chk("p2_frame_period", c - last, 8);
        last = c;
        pulses++;
      end
      if ($urandom_range(0, 3) == 0) begin
        d0 = rdig(); d1 = rdig(); d2 = rdig(); d3 = rdig();
        dp_en = 4'($urandom_range(0, 15));
        blank_lz = 1'($urandom_range(0, 1));
      end
    end
    chk("p2_frame_count_min", (pulses >= 186) ? 1 : 0, 1);

    // Asynchronous reset while digit 2 is on.
    g = 0;
    while (an4 != 4'hB && g < 64) begin
      @(negedge clk);
      g++;
    end
    chk("found_dig2", an4, 4'hB);
    #2 reset = 1'b0;
    #1;
    lit("async_rst", 4'hF, 7'h7F);
    chk("async_rst_dp", dp4, 1'b1);
    chk("async_rst_frame", frame4, 1'b0);
    chk("async_rst_an_p2", an2, 4'hF);
    d3 = 4'h1; d2 = 4'h2; d1 = 4'h3; d0 = 4'h4; dp_en = 4'h0; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_to(4);
    lit("re_pre_first", 4'hF, 7'h7F);
    chk("re_first_frame", frame4, 1'b1);
    wait_to(5);  lit("re_dig0", 4'hE, 7'h19);
    wait_to(9);  lit("re_dig1", 4'hD, 7'h30);
    wait_to(13); lit("re_dig2", 4'hB, 7'h24);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected finish before %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sevenseg_scan.md
# sevenseg_scan

Time-multiplexed driver for a 4-digit common-anode seven-segment display. It consumes the 4-bit digit values produced by the clock's digit counter chain and snapshots them once per refresh frame, so a display frame never mixes old and new values. It rotates the anode enables at a prescaled rate and drives hex-decoded, active-low segments, with optional leading-zero blanking and per-digit decimal points. It sits between the counter chain and the board's display pins.

## Interface
- PRESCALE, 50000: clocks per digit slot; legal range ≥ 2; prescaler width = $clog2(PRESCALE).
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- d0  in  4  digit 0 value (rightmost), 0x0–0xF.
- d1  in  4  digit 1 value.
- d2  in  4  digit 2 value.
- d3  in  4  digit 3 value (leftmost).
- dp_en  in  4  decimal-point request per digit; bit i maps to digit i; 1 = lit.
- blank_lz  in  1  1 = blank leading zeros on d3..d1; d0 is never blanked.
- an  out  4  anode enables, active-low; bit i maps to digit i.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- frame  out  1  one-cycle pulse marking the start of a new frame (snapshot taken).

## Operation
- Prescaler counts 0..PRESCALE-1 and wraps. tick is asserted while the count equals PRESCALE-1, so there is exactly one tick every PRESCALE clocks.
- State machine, two states:
  - OFF: entered on reset. Display dark. On tick: load snapshot, set idx=0, go to SCAN.
  - SCAN: on tick, idx advances 0→1→2→3→0. On the 3→0 transition, load the snapshot.
  - SCAN never returns to OFF except via reset.
- Snapshot: d0..d3, dp_en and blank_lz are captured together on the same edge. Input changes at any other time have no effect until the next snapshot.
- Blanking is computed from the snapshot:
  - digit 3 blank = blank_lz & (d3==0).
  - digit 2 blank = digit 3 blank & (d2==0).
  - digit 1 blank = digit 2 blank & (d1==0).
  - digit 0 is never blanked.
- Decode table (seg, hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E. A blanked digit drives 7F.
- Output register, in SCAN:
  - an = all ones except bit idx = 0.
  - seg = decode(snap[idx]), or 7F if that digit is blanked.
  - dp = ~snap_dp_en[idx]; the decimal point is unaffected by blanking.
- Output register, in OFF: an=1111, seg=7F, dp=1.
- frame is high for exactly one cycle: the cycle immediately after each snapshot-load edge.

## Timing
- Reset values (asserted asynchronously, held while reset=0):
  - prescaler=0, state=OFF, idx=0, snapshot all zero.
  - an=1111, seg=7F, dp=1, frame=0.
- After reset deasserts, the first tick is the PRESCALE-th clock edge.
- Latency, two edges:
  - Edge E (end of the tick cycle): state, idx and snapshot update; frame is high during the cycle after E.
  - Edge E+1: an, seg and dp reflect the new idx.
  - Each digit slot on the outputs lasts exactly PRESCALE cycles; one full frame = 4·PRESCALE cycles.
- Input changing on the same edge as a snapshot load: the value sampled at that edge is the one captured.
- Reset asserted mid-frame: outputs go dark immediately, without waiting for clk. On release, a fresh frame starts from digit 0 after PRESCALE clocks.
- No combinational path from inputs to outputs.

## Test plan
- Reset and first frame, PRESCALE=4, d3..d0=1,2,3,4, blank_lz=0:
  - an=1111, seg=7F until edge 5 after release.
  - frame pulses during cycle 5.
  - Then an=1110/seg=19, 1101/30, 1011/24, 0111/79, each held 4 cycles.
- Snapshot isolation: change d0 from 4 to 9 while digit 2 is displayed → digit 0 still shows 19 for the rest of that frame; the next frame shows 10.
- Leading-zero blanking, digits 0,0,7,0, blank_lz=1:
  - digits 3 and 2 show 7F with their anodes still active.
  - digit 1 shows 78; digit 0 shows 40.
  - With blank_lz=0, digits 3 and 2 show 40.
- Decimal point and full hex decode: cycle all 16 values on d0 across frames with dp_en=0001 → seg matches the decode table each frame; dp=0 only while an=1110.
- Async reset mid-operation: pull reset low between clk edges while digit 2 is displayed → an=1111, seg=7F, dp=1, frame=0 with no clock edge. After release, the restart timing is identical to the first scenario.
- Prescale boundary, PRESCALE=2 → each digit is held exactly 2 cycles; frame pulses every 8 cycles.
